// File: rtl/vga_text_console.sv
// Character-stream console engine: turns an ASCII byte stream into byte writes on the
// text video RAM, with CR/LF/BS/FF handling and hardware scroll/clear over the bus.
module vga_text_console #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          COLS      = 86,
    parameter int          ROWS      = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic [7:0]  i_char,
    output logic        i_ready,
    output logic        o_busy,
    output logic [4:0]  o_cur_row,
    output logic [6:0]  o_cur_col,
    output logic        o_rd_req,
    output logic [31:0] o_rd_addr,
    input  logic        i_rd_gnt,
    input  logic [31:0] i_rd_data,
    output logic        o_wr_req,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_be,
    input  logic        i_wr_gnt
);

    localparam logic [2:0] S_CLEAR   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_PUT     = 3'd2;
    localparam logic [2:0] S_SC_RD   = 3'd3;
    localparam logic [2:0] S_SC_DAT  = 3'd4;
    localparam logic [2:0] S_SC_WR   = 3'd5;
    localparam logic [2:0] S_SC_FILL = 3'd6;

    localparam logic [11:0] LAST_IDX = 12'(COLS * ROWS - 1);
    localparam logic [11:0] FILL_IDX = 12'(COLS * (ROWS - 1));
    localparam logic [11:0] COLS_W   = 12'(COLS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    logic [2:0]  r_state;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [11:0] r_ptr;
    logic [7:0]  r_byte;
    logic        r_noAdv;
    logic        r_run;

    logic [11:0] w_curIdx;
    logic [11:0] w_wrIdx;
    logic [7:0]  w_wrByte;
    logic [7:0]  w_rdByte;
    logic        w_wrReq;
    logic        w_rdReq;
    logic        w_wrDone;
    logic        w_rdDone;

    assign w_curIdx = 12'(r_row * COLS + r_col);
    assign w_rdByte = i_rd_data[{r_ptr[1:0], 3'b000} +: 8];

    // r_run holds the first CLEAR request off until the first clock after reset release
    always_comb begin
        w_wrReq  = 1'b0;
        w_rdReq  = 1'b0;
        w_wrIdx  = r_ptr;
        w_wrByte = 8'h20;
        case (r_state)
            S_CLEAR, S_SC_FILL: w_wrReq = r_run;
            S_PUT: begin
                w_wrReq  = 1'b1;
                w_wrIdx  = w_curIdx;
                w_wrByte = r_byte;
            end
            S_SC_WR: begin
                w_wrReq  = 1'b1;
                w_wrIdx  = r_ptr - COLS_W;
                w_wrByte = r_byte;
            end
            S_SC_RD: w_rdReq = 1'b1;
            default: ;
        endcase
    end

    assign w_wrDone  = w_wrReq & i_wr_gnt;
    assign w_rdDone  = w_rdReq & i_rd_gnt;

    assign o_wr_req  = w_wrReq;
    assign o_wr_addr = BASE_ADDR + {20'd0, w_wrIdx};
    assign o_wr_data = w_wrReq ? {4{w_wrByte}} : 32'd0;
    assign o_wr_be   = w_wrReq ? (4'b0001 << w_wrIdx[1:0]) : 4'b0000;
    assign o_rd_req  = w_rdReq;
    assign o_rd_addr = BASE_ADDR + {20'd0, r_ptr[11:2], 2'b00};

    assign i_ready   = (r_state == S_IDLE);
    assign o_busy    = (r_state != S_IDLE);
    assign o_cur_row = r_row;
    assign o_cur_col = r_col;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_CLEAR;
            r_row   <= 5'd0;
            r_col   <= 7'd0;
            r_ptr   <= 12'd0;
            r_byte  <= 8'd0;
            r_noAdv <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_CLEAR: begin
                    if (w_wrDone) begin
                        if (r_ptr == LAST_IDX) begin
                            r_ptr   <= 12'd0;
                            r_row   <= 5'd0;
                            r_col   <= 7'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr <= r_ptr + 12'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_char >= 8'h20 && i_char <= 8'h7E) begin
                            r_byte  <= i_char;
                            r_noAdv <= 1'b0;
                            r_state <= S_PUT;
                        end else if (i_char == 8'h0A) begin
                            r_col <= 7'd0;
                            if (r_row != LAST_ROW) begin
                                r_row <= r_row + 5'd1;
                            end else begin
                                r_ptr   <= COLS_W;
                                r_state <= S_SC_RD;
                            end
                        end else if (i_char == 8'h0D) begin
                            r_col <= 7'd0;
                        end else if (i_char == 8'h08) begin
                            if (r_col != 7'd0) begin
                                r_col   <= r_col - 7'd1;
                                r_byte  <= 8'h20;
                                r_noAdv <= 1'b1;
                                r_state <= S_PUT;
                            end
                        end else if (i_char == 8'h0C) begin
                            r_ptr   <= 12'd0;
                            r_state <= S_CLEAR;
                        end
                    end
                end
                S_PUT: begin
                    if (w_wrDone) begin
                        if (r_noAdv) begin
                            r_state <= S_IDLE;
                        end else if (r_col == LAST_COL) begin
                            r_col <= 7'd0;
                            if (r_row != LAST_ROW) begin
                                r_row   <= r_row + 5'd1;
                                r_state <= S_IDLE;
                            end else begin
                                r_ptr   <= COLS_W;
                                r_state <= S_SC_RD;
                            end
                        end else begin
                            r_col   <= r_col + 7'd1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                // Read data is only valid in the cycle right after a granted read
                S_SC_RD: begin
                    if (w_rdDone) r_state <= S_SC_DAT;
                end
                S_SC_DAT: begin
                    r_byte  <= w_rdByte;
                    r_state <= S_SC_WR;
                end
                S_SC_WR: begin
                    if (w_wrDone) begin
                        if (r_ptr == LAST_IDX) begin
                            r_ptr   <= FILL_IDX;
                            r_state <= S_SC_FILL;
                        end else begin
                            r_ptr   <= r_ptr + 12'd1;
                            r_state <= S_SC_RD;
                        end
                    end
                end
                S_SC_FILL: begin
                    if (w_wrDone) begin
                        if (r_ptr == LAST_IDX) begin
                            r_ptr   <= 12'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr <= r_ptr + 12'd1;
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: a byte-lane video RAM model on the bus,
// character sequences with hand-computed cursor, address and lane expectations.
module tb_vga_text_console;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          COLS   = 86;
    localparam int          ROWS   = 32;
    localparam int          NCELL  = COLS * ROWS;
    localparam int          BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iValid;
    logic [7:0]  iChar;
    logic        iReady;
    logic        oBusy;
    logic [4:0]  curRow;
    logic [6:0]  curCol;
    logic        rdReq;
    logic [31:0] rdAddr;
    logic        rdGnt = 1'b1;
    logic [31:0] rdData = 32'd0;
    logic        wrReq;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    logic        wrGnt;

    logic        rdRandom;
    logic        preloadReq;
    logic [7:0]  mem [0:NCELL-1];
    int          wrCount = 0;
    int          rdCount = 0;
    int          conflicts = 0;
    int          clearIdx = 0;
    int          clearErrs = 0;
    int          clearDone = 0;
    logic [31:0] lastWrOff = 32'd0;
    logic [31:0] lastWrData = 32'd0;
    logic [3:0]  lastWrBe = 4'd0;

    int total = 0;
    int bad = 0;

    logic [31:0] wrOff;
    logic [31:0] rdOff;
    assign wrOff = wrAddr - BASE;
    assign rdOff = rdAddr - BASE;

    always #5 clk = ~clk;

    vga_text_console #(.BASE_ADDR(BASE), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rstn(rstn), .i_valid(iValid), .i_char(iChar), .i_ready(iReady),
        .o_busy(oBusy), .o_cur_row(curRow), .o_cur_col(curCol),
        .o_rd_req(rdReq), .o_rd_addr(rdAddr), .i_rd_gnt(rdGnt), .i_rd_data(rdData),
        .o_wr_req(wrReq), .o_wr_addr(wrAddr), .o_wr_data(wrData), .o_wr_be(wrBe),
        .i_wr_gnt(wrGnt)
    );

    // Video RAM model; ungranted read cycles return garbage to catch stale captures
    always @(posedge clk) begin
        if (preloadReq) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= 8'(8'h61 + i / COLS);
        end
        if (rdReq && rdGnt) begin
            rdData  <= {mem[rdOff[11:0] + 12'd3], mem[rdOff[11:0] + 12'd2],
                        mem[rdOff[11:0] + 12'd1], mem[rdOff[11:0]]};
            rdCount <= rdCount + 1;
        end else begin
            rdData <= 32'hDEAD_BEEF;
        end
        if (rdReq && wrReq) conflicts <= conflicts + 1;
        if (wrReq && wrGnt) begin
            for (int l = 0; l < 4; l++) begin
                if (wrBe[l]) mem[{wrOff[11:2], 2'b00} + 12'(l)] <= wrData[8*l +: 8];
            end
            wrCount    <= wrCount + 1;
            lastWrOff  <= wrOff;
            lastWrData <= wrData;
            lastWrBe   <= wrBe;
            if (wrOff == 32'd0 && wrData == 32'h2020_2020 && wrBe == 4'b0001) begin
                clearIdx <= 1;
            end else if (clearIdx != 0) begin
                if (wrOff != 32'(clearIdx) || wrData != 32'h2020_2020 ||
                    wrBe != (4'b0001 << clearIdx[1:0]))
                    clearErrs <= clearErrs + 1;
                if (clearIdx == NCELL - 1) begin
                    clearIdx  <= 0;
                    clearDone <= clearDone + 1;
                end else begin
                    clearIdx <= clearIdx + 1;
                end
            end
        end
    end

    always @(negedge clk) rdGnt <= rdRandom ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sendChar(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        iValid = 1'b1;
        iChar  = c;
        while (!iReady && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) checkOutput("acceptTimeout", 32'd1, 32'd0);
        @(negedge clk);
        iValid = 1'b0;
    endtask

    task automatic waitIdle(output int cyc);
        cyc = 0;
        while (oBusy && cyc < BUDGET) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= BUDGET) checkOutput("idleTimeout", 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] c, output int cyc);
        sendChar(c);
        waitIdle(cyc);
    endtask

    task automatic checkCursor(input string tag, input int row, input int col);
        checkOutput({tag, "Row"}, 32'(curRow), 32'(row));
        checkOutput({tag, "Col"}, 32'(curCol), 32'(col));
    endtask

    task automatic preload();
        @(negedge clk);
        preloadReq = 1'b1;
        @(negedge clk);
        preloadReq = 1'b0;
    endtask

    task automatic checkScrolled(input string tag);
        int errs;
        logic [7:0] exp;
        errs = 0;
        for (int i = 0; i < NCELL; i++) begin
            exp = (i / COLS < ROWS - 1) ? 8'(8'h61 + i / COLS + 1) : 8'h20;
            if (mem[i] !== exp) errs++;
        end
        checkOutput(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        int cyc;
        int wc0;
        int rc0;
        int n;
        int errs;

        rstn = 1'b0;
        iValid = 1'b0;
        iChar = 8'h00;
        wrGnt = 1'b1;
        rdRandom = 1'b0;
        preloadReq = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 32'(iReady), 32'd0);
        checkOutput("rstBusy", 32'(oBusy), 32'd1);
        checkCursor("rst", 0, 0);
        checkOutput("rstWrReq", 32'(wrReq), 32'd0);
        checkOutput("rstRdReq", 32'(rdReq), 32'd0);
        checkOutput("rstWrBe", 32'(wrBe), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("firstReq", 32'(wrReq), 32'd1);
        checkOutput("firstAddr", wrAddr, BASE);
        @(negedge clk);
        waitIdle(cyc);
        checkOutput("rstClearDone", 32'(clearDone), 32'd1);
        checkOutput("rstClearErrs", 32'(clearErrs), 32'd0);
        checkOutput("readyAfterClear", 32'(iReady), 32'd1);
        checkCursor("afterClear", 0, 0);

        // Printable characters
        applyStimulus(8'h41, cyc);
        checkOutput("putCycles", 32'(cyc), 32'd1);
        checkOutput("aAddr", lastWrOff, 32'd0);
        checkOutput("aData", lastWrData, 32'h4141_4141);
        checkOutput("aBe", 32'(lastWrBe), 32'h1);
        applyStimulus(8'h42, cyc);
        checkOutput("bAddr", lastWrOff, 32'd1);
        checkOutput("bData", lastWrData, 32'h4242_4242);
        checkOutput("bBe", 32'(lastWrBe), 32'h2);
        checkCursor("ab", 0, 2);

        // Line wrap
        applyStimulus(8'h0D, cyc);
        checkCursor("crHome", 0, 0);
        wc0 = wrCount;
        rc0 = rdCount;
        for (int i = 0; i < COLS; i++) applyStimulus(8'h78, cyc);
        checkOutput("wrapWrites", 32'(wrCount - wc0), 32'd86);
        checkOutput("wrapLastAddr", lastWrOff, 32'd85);
        checkOutput("wrapLastBe", 32'(lastWrBe), 32'h2);
        checkOutput("wrapNoScroll", 32'(rdCount - rc0), 32'd0);
        checkCursor("wrap", 1, 0);

        // Control codes
        applyStimulus(8'h0A, cyc);
        applyStimulus(8'h0A, cyc);
        for (int i = 0; i < 5; i++) applyStimulus(8'h79, cyc);
        checkCursor("pos35", 3, 5);
        applyStimulus(8'h0D, cyc);
        checkOutput("crCycles", 32'(cyc), 32'd0);
        checkCursor("cr", 3, 0);
        applyStimulus(8'h0A, cyc);
        checkCursor("lf", 4, 0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h7A, cyc);
        applyStimulus(8'h08, cyc);
        checkOutput("bsCycles", 32'(cyc), 32'd1);
        checkOutput("bsAddr", lastWrOff, 32'd346);
        checkOutput("bsData", lastWrData, 32'h2020_2020);
        checkOutput("bsBe", 32'(lastWrBe), 32'h4);
        checkCursor("bs", 4, 2);
        applyStimulus(8'h0D, cyc);
        wc0 = wrCount;
        applyStimulus(8'h08, cyc);
        checkOutput("bsCol0Writes", 32'(wrCount - wc0), 32'd0);
        checkCursor("bsCol0", 4, 0);
        rc0 = rdCount;
        applyStimulus(8'h07, cyc);
        checkOutput("belCycles", 32'(cyc), 32'd0);
        checkOutput("belWrites", 32'(wrCount - wc0), 32'd0);
        checkOutput("belReads", 32'(rdCount - rc0), 32'd0);

        // Form feed from (10,10)
        for (int i = 0; i < 6; i++) applyStimulus(8'h0A, cyc);
        for (int i = 0; i < 10; i++) applyStimulus(8'h71, cyc);
        checkCursor("pos1010", 10, 10);
        applyStimulus(8'h0C, cyc);
        checkOutput("ffCycles", 32'(cyc), 32'd2752);
        checkOutput("ffClearDone", 32'(clearDone), 32'd2);
        checkOutput("ffClearErrs", 32'(clearErrs), 32'd0);
        checkCursor("ff", 0, 0);
        errs = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== 8'h20) errs++;
        checkOutput("ffMemSpaces", 32'(errs), 32'd0);

        // Scroll with immediate grants
        preload();
        for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A, cyc);
        checkCursor("bottom", 31, 0);
        applyStimulus(8'h0A, cyc);
        checkOutput("scrollCycles", 32'(cyc), 32'd8084);
        checkScrolled("scrollMem");
        checkCursor("scroll", 31, 0);

        // Scroll with randomly denied read grants
        rdRandom = 1'b1;
        preload();
        applyStimulus(8'h0A, cyc);
        rdRandom = 1'b0;
        checkScrolled("scrollRandMem");
        checkCursor("scrollRand", 31, 0);
        checkOutput("busConflicts", 32'(conflicts), 32'd0);

        // Reset in the middle of a clear
        sendChar(8'h0C);
        n = 0;
        while (!(wrReq && wrAddr == BASE + 32'd1000) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachIdx1000", 32'(n < BUDGET), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("midRstWrReq", 32'(wrReq), 32'd0);
        checkOutput("midRstRdReq", 32'(rdReq), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restartReq", 32'(wrReq), 32'd1);
        checkOutput("restartAddr", wrAddr, BASE);
        @(negedge clk);
        waitIdle(cyc);
        checkOutput("restartClearDone", 32'(clearDone), 32'd3);
        checkOutput("restartClearErrs", 32'(clearErrs), 32'd0);
        checkCursor("restart", 0, 0);
        checkOutput("restartReady", 32'(iReady), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
